// File: rtl/tail_light_monitor_if.sv
// Lamp bus from the tail-light sequencer plus the monitor's status outputs.
// master = sequencer/driver side, slave = monitor side.
interface tail_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [5:0]       lights;
    logic             step;
    logic             clr_err;
    logic             dir_left;
    logic             dir_right;
    logic [1:0]       phase;
    logic             sweep_done;
    logic             err;
    logic             err_sticky;
    logic [CNT_W-1:0] left_cnt;
    logic [CNT_W-1:0] right_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output lights, step, clr_err,
        input  dir_left, dir_right, phase, sweep_done, err, err_sticky,
               left_cnt, right_cnt, err_cnt
    );

    modport slave (
        input  lights, step, clr_err,
        output dir_left, dir_right, phase, sweep_done, err, err_sticky,
               left_cnt, right_cnt, err_cnt
    );
endinterface

// File: rtl/tail_light_monitor.sv
// Tail-light sweep checker: follows the expected left/right lamp sequence on each
// step strobe, counts completed sweeps and flags sequence and glitch errors.
module tail_light_monitor #(
    parameter int CNT_W = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    tail_light_monitor_if.slave bus
);

    localparam logic [5:0]       PAT_OFF = 6'b000000;
    localparam logic [5:0]       PAT_L1  = 6'b001000;
    localparam logic [5:0]       PAT_L2  = 6'b011000;
    localparam logic [5:0]       PAT_L3  = 6'b111000;
    localparam logic [5:0]       PAT_R1  = 6'b000100;
    localparam logic [5:0]       PAT_R2  = 6'b000110;
    localparam logic [5:0]       PAT_R3  = 6'b000111;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6
    } state_t;

    state_t           state, state_n;
    logic [5:0]       lights_q;
    logic             done_l, done_r, seq_err, glitch, err_n;
    logic             dir_left_n, dir_right_n;
    logic [1:0]       phase_n;

    logic             dir_left_r, dir_right_r, sweep_done_r, err_r, err_sticky_r;
    logic [1:0]       phase_r;
    logic [CNT_W-1:0] left_cnt_r, right_cnt_r, err_cnt_r;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            lights_q <= '0;
        end else begin
            state    <= state_n;
            lights_q <= bus.lights;
        end
    end

    // A mismatching pattern always drops back to IDLE; it is never taken as a new start.
    always_comb begin
        state_n = state;
        done_l  = 1'b0;
        done_r  = 1'b0;
        seq_err = 1'b0;
        glitch  = 1'b0;
        if (bus.step) begin
            unique case (state)
                IDLE: begin
                    if (bus.lights == PAT_L1)       state_n = L1;
                    else if (bus.lights == PAT_R1)  state_n = R1;
                    else if (bus.lights != PAT_OFF) seq_err = 1'b1;
                end
                L1: if (bus.lights == PAT_L2) state_n = L2;
                    else begin state_n = IDLE; seq_err = 1'b1; end
                L2: if (bus.lights == PAT_L3) state_n = L3;
                    else begin state_n = IDLE; seq_err = 1'b1; end
                L3: begin
                    state_n = IDLE;
                    if (bus.lights == PAT_OFF) done_l  = 1'b1;
                    else                       seq_err = 1'b1;
                end
                R1: if (bus.lights == PAT_R2) state_n = R2;
                    else begin state_n = IDLE; seq_err = 1'b1; end
                R2: if (bus.lights == PAT_R3) state_n = R3;
                    else begin state_n = IDLE; seq_err = 1'b1; end
                R3: begin
                    state_n = IDLE;
                    if (bus.lights == PAT_OFF) done_r  = 1'b1;
                    else                       seq_err = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    seq_err = 1'b1;
                end
            endcase
        end else if (bus.lights != lights_q) begin
            glitch = 1'b1;
        end
        err_n = seq_err | glitch;
    end

    always_comb begin
        dir_left_n  = 1'b0;
        dir_right_n = 1'b0;
        phase_n     = 2'd0;
        unique case (state_n)
            L1:      begin dir_left_n  = 1'b1; phase_n = 2'd1; end
            L2:      begin dir_left_n  = 1'b1; phase_n = 2'd2; end
            L3:      begin dir_left_n  = 1'b1; phase_n = 2'd3; end
            R1:      begin dir_right_n = 1'b1; phase_n = 2'd1; end
            R2:      begin dir_right_n = 1'b1; phase_n = 2'd2; end
            R3:      begin dir_right_n = 1'b1; phase_n = 2'd3; end
            default: ;
        endcase
    end

    // Status is registered from the next-state view so it lands the cycle after the strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_left_r   <= 1'b0;
            dir_right_r  <= 1'b0;
            phase_r      <= 2'd0;
            sweep_done_r <= 1'b0;
            err_r        <= 1'b0;
            err_sticky_r <= 1'b0;
            left_cnt_r   <= '0;
            right_cnt_r  <= '0;
            err_cnt_r    <= '0;
        end else begin
            dir_left_r   <= dir_left_n;
            dir_right_r  <= dir_right_n;
            phase_r      <= phase_n;
            sweep_done_r <= done_l | done_r;
            err_r        <= err_n;
            if (done_l && left_cnt_r != CNT_MAX)
                left_cnt_r <= left_cnt_r + 1'b1;
            if (done_r && right_cnt_r != CNT_MAX)
                right_cnt_r <= right_cnt_r + 1'b1;
            // An error in the same cycle as a clear restarts the count at one.
            if (err_n) begin
                err_sticky_r <= 1'b1;
                if (bus.clr_err)               err_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
                else if (err_cnt_r != CNT_MAX) err_cnt_r <= err_cnt_r + 1'b1;
            end else if (bus.clr_err) begin
                err_sticky_r <= 1'b0;
                err_cnt_r    <= '0;
            end
        end
    end

    assign bus.dir_left   = dir_left_r;
    assign bus.dir_right  = dir_right_r;
    assign bus.phase      = phase_r;
    assign bus.sweep_done = sweep_done_r;
    assign bus.err        = err_r;
    assign bus.err_sticky = err_sticky_r;
    assign bus.left_cnt   = left_cnt_r;
    assign bus.right_cnt  = right_cnt_r;
    assign bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Bench for tail_light_monitor: two instances (CNT_W=8 and CNT_W=2) on shared stimulus,
// checked every cycle against a sweep-level reference model.
module tb_tail_light_monitor;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [5:0] lights = '0;
    logic       step = 1'b0;
    logic       clr_err = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    tail_light_monitor_if #(.CNT_W(8)) bus_a ();
    tail_light_monitor_if #(.CNT_W(2)) bus_b ();

    assign bus_a.lights  = lights;
    assign bus_a.step    = step;
    assign bus_a.clr_err = clr_err;
    assign bus_b.lights  = lights;
    assign bus_b.step    = step;
    assign bus_b.clr_err = clr_err;

    tail_light_monitor #(.CNT_W(8)) dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_a));
    tail_light_monitor #(.CNT_W(2)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_b));

    // Reference model: sweep direction (0 none, 1 left, 2 right) and lamps lit so far.
    int m_dir, m_lit, m_lq;
    int m_lcnt, m_rcnt, m_ecnt;
    bit m_done, m_err, m_sticky;

    // Pattern with n lamps lit in direction d; n==4 is the all-off completion.
    function automatic int pat(input int d, input int n);
        if (n >= 4) return 0;
        if (d == 1) return ((1 << n) - 1) << 3;
        return (7 << (3 - n)) & 7;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_dir = 0; m_lit = 0; m_lq = 0;
        m_lcnt = 0; m_rcnt = 0; m_ecnt = 0;
        m_done = 0; m_err = 0; m_sticky = 0;
    endtask

    task automatic model_step();
        int l;
        l = int'(lights);
        m_done = 0;
        m_err  = 0;
        if (!step) begin
            if (l != m_lq) m_err = 1;
        end else if (m_dir == 0) begin
            if (l == pat(1, 1))      begin m_dir = 1; m_lit = 1; end
            else if (l == pat(2, 1)) begin m_dir = 2; m_lit = 1; end
            else if (l != 0)         m_err = 1;
        end else if (l == pat(m_dir, m_lit + 1)) begin
            if (m_lit == 3) begin
                m_done = 1;
                if (m_dir == 1) m_lcnt++; else m_rcnt++;
                m_dir = 0; m_lit = 0;
            end else begin
                m_lit++;
            end
        end else begin
            m_err = 1; m_dir = 0; m_lit = 0;
        end
        if (m_err) begin
            m_sticky = 1;
            m_ecnt   = clr_err ? 1 : m_ecnt + 1;
        end else if (clr_err) begin
            m_sticky = 0;
            m_ecnt   = 0;
        end
        m_lq = l;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " dir_left"},   int'(bus_a.dir_left),   int'(m_dir == 1));
        chk({tag, " dir_right"},  int'(bus_a.dir_right),  int'(m_dir == 2));
        chk({tag, " phase"},      int'(bus_a.phase),      m_lit);
        chk({tag, " sweep_done"}, int'(bus_a.sweep_done), int'(m_done));
        chk({tag, " err"},        int'(bus_a.err),        int'(m_err));
        chk({tag, " err_sticky"}, int'(bus_a.err_sticky), int'(m_sticky));
        chk({tag, " left_cnt"},   int'(bus_a.left_cnt),   sat(m_lcnt, 8));
        chk({tag, " right_cnt"},  int'(bus_a.right_cnt),  sat(m_rcnt, 8));
        chk({tag, " err_cnt"},    int'(bus_a.err_cnt),    sat(m_ecnt, 8));
        chk({tag, " b.phase"},    int'(bus_b.phase),      m_lit);
        chk({tag, " b.err"},      int'(bus_b.err),        int'(m_err));
        chk({tag, " b.left_cnt"}, int'(bus_b.left_cnt),   sat(m_lcnt, 2));
        chk({tag, " b.right_cnt"},int'(bus_b.right_cnt),  sat(m_rcnt, 2));
        chk({tag, " b.err_cnt"},  int'(bus_b.err_cnt),    sat(m_ecnt, 2));
    endtask

    // Called from a negedge; returns at the following negedge.
    task automatic tick(input string tag, input int l, input bit s, input bit c);
        lights  = 6'(l);
        step    = s;
        clr_err = c;
        @(posedge Clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge Clk);
    endtask

    task automatic do_reset(input string tag);
        #1;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        lights = '0; step = 1'b0; clr_err = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic sweep(input string tag, input int d);
        for (int n = 1; n <= 4; n++) tick(tag, pat(d, n), 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r, l;
        model_reset();
        @(negedge Clk);
        check_all("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        sweep("left", 1);
        sweep("right2x", 2);
        sweep("right2x", 2);

        tick("seq", pat(1, 1), 1'b1, 1'b0);
        tick("seq", pat(1, 2), 1'b1, 1'b0);
        tick("seq", 6'b000110, 1'b1, 1'b0);
        tick("seq", pat(2, 1), 1'b1, 1'b0);
        tick("seq", 0, 1'b1, 1'b0);

        tick("glitch", pat(1, 1), 1'b1, 1'b0);
        tick("glitch", pat(1, 1), 1'b0, 1'b0);
        tick("glitch", pat(1, 2), 1'b0, 1'b0);
        tick("glitch", pat(1, 2), 1'b1, 1'b0);
        tick("glitch", pat(1, 3), 1'b1, 1'b0);
        tick("glitch", 0, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) sweep("sat", 1);
        tick("errclr", 6'b111111, 1'b1, 1'b1);
        tick("clr", 6'b111111, 1'b0, 1'b1);

        tick("rstmid", pat(2, 1), 1'b1, 1'b0);
        tick("rstmid", pat(2, 2), 1'b1, 1'b0);
        do_reset("rstmid");
        sweep("afterrst", 2);

        tick("relglitch", 6'b010101, 1'b1, 1'b0);
        do_reset("relrst");
        tick("relglitch", 6'b001000, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 2) begin
                do_reset("rand_rst");
                continue;
            end
            if (r < 90) begin
                if (m_dir == 0) begin
                    case ($urandom_range(0, 2))
                        0:       l = 0;
                        1:       l = pat(1, 1);
                        default: l = pat(2, 1);
                    endcase
                end else begin
                    l = pat(m_dir, m_lit + 1);
                end
                tick("rand_step", l, 1'b1, $urandom_range(0, 19) == 0);
            end else if (r < 110) begin
                tick("rand_bad", int'($urandom_range(0, 63)), 1'b1, $urandom_range(0, 19) == 0);
            end else if (r < 185) begin
                tick("rand_hold", int'(lights), 1'b0, $urandom_range(0, 19) == 0);
            end else begin
                tick("rand_glitch", int'($urandom_range(0, 63)), 1'b0, $urandom_range(0, 19) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
